// File: rtl/cpu_ctrl_fsm_if.sv
// Signal bundle between the instruction decoder/datapath and the multicycle
// control FSM. The controller uses the slave modport, the decoder/datapath
// side uses the master modport.
//
// Handshake: there is no valid/ready pair and no back-pressure. The decoder
// must hold i_type/i_wb/i_cond_true valid during the DECODE state, when they
// are captured. o_instr_done is a one-cycle retire pulse in the last state of
// each instruction. i_halt is only acted on at instruction boundaries and
// while halted.
interface cpu_ctrl_fsm_if;
  logic [1:0] i_type;
  logic       i_wb;
  logic       i_cond_true;
  logic       i_halt;
  logic       o_pce;
  logic       o_lscntl;
  logic       o_we;
  logic       o_i_en;
  logic       o_s_muximm;
  logic       o_reg_wen;
  logic       o_flags_en;
  logic       o_s_mem_to_bus;
  logic       o_npc_ctrl;
  logic       o_mem_pc_ctrl;
  logic       o_instr_done;
  logic [3:0] o_state;

  modport master (
    output i_type, i_wb, i_cond_true, i_halt,
    input  o_pce, o_lscntl, o_we, o_i_en, o_s_muximm, o_reg_wen, o_flags_en,
           o_s_mem_to_bus, o_npc_ctrl, o_mem_pc_ctrl, o_instr_done, o_state
  );

  modport slave (
    input  i_type, i_wb, i_cond_true, i_halt,
    output o_pce, o_lscntl, o_we, o_i_en, o_s_muximm, o_reg_wen, o_flags_en,
           o_s_mem_to_bus, o_npc_ctrl, o_mem_pc_ctrl, o_instr_done, o_state
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit CPU: fetch, decode, ALU execute,
// load/store and jump-and-link, with configurable fetch/RAM wait states,
// conditional jumps and halt at instruction boundaries. Outputs are Moore,
// decoded from the state and the fields captured at decode.
module cpu_ctrl_fsm #(
  parameter int FETCH_LAT = 1,
  parameter int MEM_LAT   = 1,
  parameter int JMP_COND  = 1
) (
  input  logic           clk,
  input  logic           reset,
  cpu_ctrl_fsm_if.slave  io_bus
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_EXEC       = 4'd2,
    S_MEM_SETUP  = 4'd3,
    S_MEM_ACC    = 4'd4,
    S_MEM_DONE   = 4'd5,
    S_JMP_LINK   = 4'd6,
    S_JMP_SETTLE = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  localparam logic [3:0] C_FETCH_LOAD = 4'(FETCH_LAT - 1);
  localparam logic [3:0] C_MEM_LOAD   = 4'(MEM_LAT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic [1:0] r_type_q;
  logic       r_wb_q;
  logic       r_taken_q;
  logic       w_taken;

  logic w_pce, w_lscntl, w_we, w_i_en, w_s_muximm, w_reg_wen, w_flags_en;
  logic w_s_mem_to_bus, w_npc_ctrl, w_mem_pc_ctrl, w_instr_done;

  // With conditional jumps disabled every jType is taken.
  assign w_taken = (JMP_COND != 0) ? io_bus.i_cond_true : 1'b1;

  // State register, wait-state counter and decode-time capture of the instruction fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= C_FETCH_LOAD;
      r_type_q   <= 2'b00;
      r_wb_q     <= 1'b0;
      r_taken_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_wait_cnt <= C_FETCH_LOAD;
      else if (w_next == S_MEM_ACC && r_state != S_MEM_ACC)
        r_wait_cnt <= C_MEM_LOAD;
      else if (r_wait_cnt != 4'd0)
        r_wait_cnt <= r_wait_cnt - 4'd1;
      if (r_state == S_DECODE) begin
        r_type_q  <= io_bus.i_type;
        r_wb_q    <= io_bus.i_wb;
        r_taken_q <= w_taken;
      end
    end
  end

  // Next-state selection; unused encodings recover to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = (r_wait_cnt == 4'd0) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (io_bus.i_type)
          2'b00, 2'b01: w_next = S_EXEC;
          2'b10:        w_next = S_MEM_SETUP;
          default:      w_next = S_JMP_LINK;
        endcase
      end
      S_MEM_SETUP: w_next = S_MEM_ACC;
      S_MEM_ACC:   w_next = (r_wait_cnt == 4'd0) ? S_MEM_DONE : S_MEM_ACC;
      S_JMP_LINK:  w_next = S_JMP_SETTLE;
      S_EXEC, S_MEM_DONE, S_JMP_SETTLE:
                   w_next = io_bus.i_halt ? S_HALTED : S_FETCH;
      S_HALTED:    w_next = io_bus.i_halt ? S_HALTED : S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  // Datapath control decode; s_muxImm in DECODE follows the live type so the
  // immediate reaches the ALU input one cycle early.
  always_comb begin
    w_pce          = 1'b0;
    w_lscntl       = 1'b0;
    w_we           = 1'b0;
    w_i_en         = 1'b0;
    w_s_muximm     = 1'b0;
    w_reg_wen      = 1'b0;
    w_flags_en     = 1'b0;
    w_s_mem_to_bus = 1'b0;
    w_npc_ctrl     = 1'b0;
    w_mem_pc_ctrl  = 1'b0;
    w_instr_done   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_i_en   = 1'b1;
        w_lscntl = 1'b1;
      end
      S_DECODE: begin
        w_lscntl   = 1'b1;
        w_s_muximm = (io_bus.i_type == 2'b01);
      end
      S_EXEC: begin
        w_pce        = 1'b1;
        w_lscntl     = 1'b1;
        w_s_muximm   = (r_type_q == 2'b01);
        w_reg_wen    = r_wb_q;
        w_flags_en   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_ACC: begin
        w_we           = r_wb_q;
        w_reg_wen      = ~r_wb_q;
        w_s_mem_to_bus = ~r_wb_q;
      end
      S_MEM_DONE: begin
        w_pce        = 1'b1;
        w_lscntl     = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JMP_LINK: begin
        w_pce          = 1'b1;
        w_lscntl       = 1'b1;
        w_npc_ctrl     = r_taken_q;
        w_reg_wen      = r_wb_q & r_taken_q;
        w_s_mem_to_bus = r_wb_q & r_taken_q;
        w_mem_pc_ctrl  = r_wb_q & r_taken_q;
      end
      S_JMP_SETTLE: begin
        w_lscntl     = 1'b1;
        w_instr_done = 1'b1;
      end
      S_HALTED:    w_lscntl = 1'b1;
      default:     w_lscntl = 1'b0;
    endcase
  end

  assign io_bus.o_pce          = w_pce;
  assign io_bus.o_lscntl       = w_lscntl;
  assign io_bus.o_we           = w_we;
  assign io_bus.o_i_en         = w_i_en;
  assign io_bus.o_s_muximm     = w_s_muximm;
  assign io_bus.o_reg_wen      = w_reg_wen;
  assign io_bus.o_flags_en     = w_flags_en;
  assign io_bus.o_s_mem_to_bus = w_s_mem_to_bus;
  assign io_bus.o_npc_ctrl     = w_npc_ctrl;
  assign io_bus.o_mem_pc_ctrl  = w_mem_pc_ctrl;
  assign io_bus.o_instr_done   = w_instr_done;
  assign io_bus.o_state        = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm. Three instances with different parameter sets share
// the same stimulus; one instance at a time is selected for checking. The
// driver builds the expected per-cycle control word of each instruction from
// its class, latency and the per-state output table, and pushes it into a
// queue; a negedge monitor pops and compares against the selected instance.
module tb_cpu_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] drv_type;
  logic drv_wb, drv_cond, drv_halt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sel   = 2;
  int cfg_fl = 1;
  int cfg_ml = 1;
  int cfg_jc = 1;

  logic [14:0] exp_q[$];
  logic [14:0] mon_e, mon_a;
  logic [14:0] w_act_a, w_act_b, w_act_c;

  // Clock
  always #5 clk = ~clk;

  cpu_ctrl_fsm_if bus_a ();
  cpu_ctrl_fsm_if bus_b ();
  cpu_ctrl_fsm_if bus_c ();

  assign bus_a.i_type = drv_type;  assign bus_a.i_wb = drv_wb;
  assign bus_a.i_cond_true = drv_cond;  assign bus_a.i_halt = drv_halt;
  assign bus_b.i_type = drv_type;  assign bus_b.i_wb = drv_wb;
  assign bus_b.i_cond_true = drv_cond;  assign bus_b.i_halt = drv_halt;
  assign bus_c.i_type = drv_type;  assign bus_c.i_wb = drv_wb;
  assign bus_c.i_cond_true = drv_cond;  assign bus_c.i_halt = drv_halt;

  cpu_ctrl_fsm #(.FETCH_LAT(2), .MEM_LAT(3), .JMP_COND(1)) dut_a (
    .clk(clk), .reset(reset), .io_bus(bus_a.slave));
  cpu_ctrl_fsm #(.FETCH_LAT(1), .MEM_LAT(1), .JMP_COND(0)) dut_b (
    .clk(clk), .reset(reset), .io_bus(bus_b.slave));
  cpu_ctrl_fsm dut_c (
    .clk(clk), .reset(reset), .io_bus(bus_c.slave));

  assign w_act_a = {bus_a.o_state, bus_a.o_pce, bus_a.o_lscntl, bus_a.o_we,
                    bus_a.o_i_en, bus_a.o_s_muximm, bus_a.o_reg_wen, bus_a.o_flags_en,
                    bus_a.o_s_mem_to_bus, bus_a.o_npc_ctrl, bus_a.o_mem_pc_ctrl,
                    bus_a.o_instr_done};
  assign w_act_b = {bus_b.o_state, bus_b.o_pce, bus_b.o_lscntl, bus_b.o_we,
                    bus_b.o_i_en, bus_b.o_s_muximm, bus_b.o_reg_wen, bus_b.o_flags_en,
                    bus_b.o_s_mem_to_bus, bus_b.o_npc_ctrl, bus_b.o_mem_pc_ctrl,
                    bus_b.o_instr_done};
  assign w_act_c = {bus_c.o_state, bus_c.o_pce, bus_c.o_lscntl, bus_c.o_we,
                    bus_c.o_i_en, bus_c.o_s_muximm, bus_c.o_reg_wen, bus_c.o_flags_en,
                    bus_c.o_s_mem_to_bus, bus_c.o_npc_ctrl, bus_c.o_mem_pc_ctrl,
                    bus_c.o_instr_done};

  // Control word: state, PCe, Lscntl, WE, i_en, s_muxImm, reg_Wen, flagsEn,
  // s_mem_to_bus, npc_ctrl, mem_pc_ctrl, instr_done.
  function automatic logic [14:0] mk(input logic [3:0] st, input logic pce, ls, we,
                                     ien, mux, rwen, flg, mtb, npc, mpc, done);
    return {st, pce, ls, we, ien, mux, rwen, flg, mtb, npc, mpc, done};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = (sel == 0) ? w_act_a : (sel == 1) ? w_act_b : w_act_c;
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL ctrl_word cyc=%0d dut=%0d got=%h exp=%h", cyc, sel, mon_a, mon_e);
      end
    end
  end

  task automatic tick(input logic [14:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Inputs after decode are don't-care for the current instruction.
  task automatic scramble();
    drv_type = 2'($urandom_range(0, 3));
    drv_wb   = 1'($urandom_range(0, 1));
    drv_cond = 1'($urandom_range(0, 1));
    drv_halt = 1'($urandom_range(0, 1));
  endtask

  task automatic start_phase(input int s, input int fl, input int ml, input int jc);
    sel = s; cfg_fl = fl; cfg_ml = ml; cfg_jc = jc;
    reset = 1'b1;
    drv_halt = 1'b0;
    @(posedge clk);
    #1;
    tick(mk(4'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
  endtask

  // One instruction; optionally ends in halt for 'hold' cycles, or is cut
  // short by a two-cycle reset in its first RAM access cycle.
  task automatic run_instr(input logic [1:0] t, input logic w, input logic c,
                           input logic h, input int hold, input bit abort);
    logic tk;
    tk = (cfg_jc != 0) ? c : 1'b1;
    for (int i = 0; i < cfg_fl; i++) begin
      drv_type = t; drv_wb = w; drv_cond = c; drv_halt = 1'($urandom_range(0, 1));
      tick(mk(4'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    drv_type = t; drv_wb = w; drv_cond = c; drv_halt = 1'($urandom_range(0, 1));
    tick(mk(4'd1, 0, 1, 0, 0, (t == 2'd1), 0, 0, 0, 0, 0, 0));
    case (t)
      2'd0, 2'd1: begin
        scramble(); drv_halt = h;
        tick(mk(4'd2, 1, 1, 0, 0, (t == 2'd1), w, 1, 0, 0, 0, 1));
      end
      2'd2: begin
        scramble();
        tick(mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < cfg_ml; i++) begin
          scramble();
          if (abort) begin
            reset = 1'b1;
            tick(mk(4'd4, 0, 0, w, 0, 0, !w, 0, !w, 0, 0, 0));
            tick(mk(4'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            reset = 1'b0;
            return;
          end
          tick(mk(4'd4, 0, 0, w, 0, 0, !w, 0, !w, 0, 0, 0));
        end
        scramble(); drv_halt = h;
        tick(mk(4'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      default: begin
        scramble();
        tick(mk(4'd6, 1, 1, 0, 0, 0, w & tk, 0, w & tk, tk, w & tk, 0));
        scramble(); drv_halt = h;
        tick(mk(4'd7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
    endcase
    if (h) begin
      for (int i = 0; i < hold; i++) begin
        scramble();
        drv_halt = (i < hold - 1);
        tick(mk(4'd8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                $urandom_range(1, 3), 1'b0);
    end
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    drv_type = 2'b00; drv_wb = 1'b0; drv_cond = 1'b0; drv_halt = 1'b0;
    @(posedge clk);
    #1;

    // Default latencies, conditional jumps
    start_phase(2, 1, 1, 1);
    run_instr(2'd0, 1'b1, 1'b0, 1'b0, 1, 1'b0);  // rType with writeback
    run_instr(2'd1, 1'b1, 1'b0, 1'b0, 1, 1'b0);  // iType
    run_instr(2'd2, 1'b1, 1'b0, 1'b0, 1, 1'b1);  // store cut by reset in MEM_ACC
    run_instr(2'd3, 1'b1, 1'b1, 1'b0, 1, 1'b0);  // taken jump and link
    run_instr(2'd3, 1'b1, 1'b0, 1'b0, 1, 1'b0);  // not-taken jump
    run_instr(2'd2, 1'b0, 1'b0, 1'b1, 2, 1'b0);  // load then halt
    run_random(40);

    // FETCH_LAT=2, MEM_LAT=3
    start_phase(0, 2, 3, 1);
    run_instr(2'd2, 1'b0, 1'b0, 1'b0, 1, 1'b0);  // load
    run_instr(2'd2, 1'b1, 1'b0, 1'b0, 1, 1'b0);  // store
    run_instr(2'd2, 1'b1, 1'b0, 1'b1, 3, 1'b0);  // store then halt
    run_random(40);

    // Unconditional jumps
    start_phase(1, 1, 1, 0);
    run_instr(2'd3, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    run_instr(2'd3, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    run_random(30);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Parametrised next-generation multicycle control FSM for the 16-bit CPU. It sequences fetch, decode, ALU execute, load/store, and jump-and-link.
- New over the previous controller:
  - synchronous reset;
  - configurable fetch and RAM wait states;
  - instruction type, writeback and branch condition latched at decode;
  - conditional jumps;
  - halt at instruction boundary;
  - instruction-retire pulse and state visibility.
- Sits between the instruction register/decoder and the datapath enables (PC, regfile, RAM, muxes).

Parameters:
- FETCH_LAT, 1, cycles i_en is held for instruction fetch (1..15).
- MEM_LAT, 1, cycles the RAM access state is held (1..15).
- JMP_COND, 1, 1: jType jumps only when cond_true is sampled high at decode; 0: jumps unconditional.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- type  in  2  instruction class: 00 rType, 01 iType, 10 pType (load/store), 11 jType
- wb  in  1  rType/iType: regfile writeback; pType: 1=store, 0=load; jType: write link
- cond_true  in  1  branch condition from flags logic
- halt  in  1  request to stop at the next instruction boundary
- PCe, Lscntl, WE, i_en, s_muxImm, reg_Wen, flagsEn, s_mem_to_bus, npc_ctrl, mem_pc_ctrl  out  1 each  datapath controls, same meaning as the existing datapath
- instr_done  out  1  one-cycle pulse in the final state of every instruction
- state_o  out  4  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM_SETUP=3, MEM_ACC=4, MEM_DONE=5, JMP_LINK=6, JMP_SETTLE=7, HALTED=8.
- Outputs are Moore, decoded from state and latched regs. Exception: s_muxImm in DECODE uses the live type.
- Reset (sync, highest priority):
  - state=FETCH; wait_cnt=FETCH_LAT-1; type_q=00, wb_q=0, taken_q=0.
  - Outputs during and after reset are the FETCH values: i_en=1, Lscntl=1, all others 0.
  - Reset in any state, including MEM_ACC with WE=1, forces FETCH on that edge, so WE is low from the next cycle.
- wait_cnt:
  - Loaded with LAT-1 on entry to FETCH or MEM_ACC.
  - Decrements each cycle while nonzero.
  - The state exits when wait_cnt==0.
- Transitions:
  - FETCH -> DECODE when wait_cnt==0.
  - DECODE latches type_q=type, wb_q=wb, taken_q=(JMP_COND ? cond_true : 1). Then: type 00/01 -> EXEC; 10 -> MEM_SETUP; 11 -> JMP_LINK.
  - MEM_SETUP -> MEM_ACC; MEM_ACC -> MEM_DONE when wait_cnt==0.
  - JMP_LINK -> JMP_SETTLE.
  - EXEC, MEM_DONE, JMP_SETTLE -> HALTED if halt==1, else FETCH.
  - HALTED -> FETCH when halt==0.
  - Unused encodings -> FETCH.
- Changes on type/wb/cond_true after DECODE have no effect on the current instruction.
- Output values per state; any output not listed is 0:
  - FETCH: i_en=1, Lscntl=1.
  - DECODE: Lscntl=1, s_muxImm=(type==01).
  - EXEC: PCe=1, Lscntl=1, s_muxImm=(type_q==01), reg_Wen=wb_q, flagsEn=1, instr_done=1.
  - MEM_SETUP: Lscntl=0.
  - MEM_ACC: Lscntl=0, WE=wb_q, reg_Wen=~wb_q, s_mem_to_bus=~wb_q. Held for all MEM_LAT cycles.
  - MEM_DONE: PCe=1, Lscntl=1, instr_done=1.
  - JMP_LINK: PCe=1, Lscntl=1, npc_ctrl=taken_q, reg_Wen=s_mem_to_bus=mem_pc_ctrl=wb_q&taken_q.
  - JMP_SETTLE: Lscntl=1, instr_done=1. PCe=0, so the PC updates exactly once per jump.
  - HALTED: Lscntl=1.
- Latency (cycles from FETCH entry to instr_done inclusive):
  - r/iType: FETCH_LAT+2.
  - pType: FETCH_LAT+MEM_LAT+3.
  - jType: FETCH_LAT+3.
- PCe is high for exactly one cycle per instruction.
- WE is never high outside MEM_ACC.
- reg_Wen is never high in FETCH, DECODE, MEM_SETUP or HALTED.

Test Plan:
- Reset: assert reset 2 cycles mid-MEM_ACC with wb=1 -> next cycle state_o=0, WE=0, i_en=1. Defaults FETCH_LAT=1, MEM_LAT=1.
- rType ADD, wb=1, defaults -> state_o 0,1,2; EXEC has PCe=1, reg_Wen=1, flagsEn=1, instr_done=1. iType -> s_muxImm=1 in DECODE and EXEC. Toggle type to 10 during EXEC -> no effect.
- MEM_LAT=3, FETCH_LAT=2:
  - load (wb=0) -> FETCH 2 cycles, MEM_ACC 3 cycles with reg_Wen=1, s_mem_to_bus=1, WE=0; instr_done in cycle 8.
  - store (wb=1) -> WE=1 for exactly 3 cycles, reg_Wen=0.
- jType, wb=1, cond_true=1 at DECODE -> JMP_LINK: PCe=npc_ctrl=reg_Wen=mem_pc_ctrl=1.
- jType, cond_true=0 -> JMP_LINK: PCe=1, npc_ctrl=0, reg_Wen=0.
- jType, JMP_COND=0, cond_true=0 -> npc_ctrl=1.
- halt=1 raised during a pType MEM_ACC -> MEM_DONE completes (instr_done=1), then state_o=8 with all enables 0. Drop halt -> FETCH next cycle.
